// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared types and constants for the period meter.
// The state type is shared by the top level and any debug logic that
// wants to observe the measurement FSM.
package period_meter_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } pm_state_t;

   // Two flops is the least that gives a metastability-safe synchroniser.
   localparam int PM_SYNC_MIN = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous level into the clk domain through
// a SYNC_STAGES flop chain, then flags each 0->1 transition with a
// registered one-cycle pulse on rise.
module sync_edge_detect
   import period_meter_pkg::*;
#(
   parameter int SYNC_STAGES = 2
)
(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   // A request for fewer stages than the safe minimum is quietly raised to it.
   localparam int STAGES = (SYNC_STAGES < PM_SYNC_MIN) ? PM_SYNC_MIN : SYNC_STAGES;

   logic [STAGES-1:0] syncChain_q;
   logic              prevLevel_q;
   logic              rise_q;

   // Shift the input through the synchroniser and compare the settled level
   // with its previous value to produce the rising-edge pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         syncChain_q <= '0;
         prevLevel_q <= 1'b0;
         rise_q      <= 1'b0;
      end else begin
         syncChain_q <= {syncChain_q[STAGES-2:0], d};
         prevLevel_q <= syncChain_q[STAGES-1];
         rise_q      <= syncChain_q[STAGES-1] & ~prevLevel_q;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/period_meter.sv
// period_meter: counts clkcnt cycles between consecutive rising edges of the
// asynchronous sig_in and offers each period on a valid/ready output, with a
// flag when the count saturated at all-ones.
// Optional feature: define PERIOD_METER_OVERRUN_EN to add the sticky
// overrun output that records a measurement dropped while the consumer stalled.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int COUNT_WIDTH = 16,
   parameter int SYNC_STAGES = 2
)
(
   input  logic                   rst,
   input  logic                   clkcnt,
   input  logic                   sig_in,
   input  logic                   meas_ready,
   output logic [COUNT_WIDTH-1:0] meas,
   output logic                   meas_valid,
   output logic                   meas_sat,
   output logic                   busy
`ifdef PERIOD_METER_OVERRUN_EN
   ,
   output logic                   overrun
`endif
);

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

   logic                   sigEdge;
   pm_state_t              state_q;
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] count_d;
   logic [COUNT_WIDTH-1:0] meas_q;
   logic                   measValid_q;
   logic                   measSat_q;
   logic                   capture;
   logic                   transfer;
   logic                   accept;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) uSyncEdge (
      .clk  (clkcnt),
      .rst  (rst),
      .d    (sig_in),
      .rise (sigEdge)
   );

   // The first edge only arms the block; later edges close a period.
   assign capture  = (state_q == MEASURE) && sigEdge;
   assign transfer = measValid_q && meas_ready;
   assign accept   = capture && (!measValid_q || meas_ready);

   // Next counter value: restart at 1 on any edge, otherwise count up and
   // stick at all-ones so long gaps read as saturated rather than wrapping.
   always_comb begin
      count_d = count_q;
      case (state_q)
         IDLE: begin
            if (sigEdge) count_d = COUNT_ONE;
         end
         MEASURE: begin
            if (sigEdge)                 count_d = COUNT_ONE;
            else if (count_q != COUNT_MAX) count_d = count_q + COUNT_ONE;
         end
         default: count_d = count_q;
      endcase
   end

   // Measurement FSM and period counter; once armed the block stays in
   // MEASURE until reset.
   always_ff @(posedge clkcnt or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         count_q <= count_d;
         if (sigEdge) state_q <= MEASURE;
      end
   end

   // Output holding register: a capture loads it when it is empty or being
   // read this cycle; otherwise the held value wins and the new one is lost.
   always_ff @(posedge clkcnt or posedge rst) begin
      if (rst) begin
         meas_q      <= '0;
         measValid_q <= 1'b0;
         measSat_q   <= 1'b0;
      end else if (accept) begin
         meas_q      <= count_q;
         measSat_q   <= (count_q == COUNT_MAX);
         measValid_q <= 1'b1;
      end else if (transfer) begin
         measValid_q <= 1'b0;
      end
   end

   assign meas       = meas_q;
   assign meas_valid = measValid_q;
   assign meas_sat   = measSat_q;
   assign busy       = (state_q == MEASURE);

`ifdef PERIOD_METER_OVERRUN_EN
   logic drop;
   logic overrun_q;

   assign drop = capture && measValid_q && !meas_ready;

   // Sticky record of a lost measurement, cleared by a clean read.
   always_ff @(posedge clkcnt or posedge rst) begin
      if (rst)           overrun_q <= 1'b0;
      else if (drop)     overrun_q <= 1'b1;
      else if (transfer) overrun_q <= 1'b0;
   end

   assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: drives sig_in with directed and random square waves into
// a 16-bit and a 4-bit period_meter and compares their outputs with
// periods computed from the driven rise times.
// Build with PERIOD_METER_OVERRUN_EN defined to also exercise overrun.
module tb_period_meter;

   typedef struct {
      int val;
      bit sat;
   } meas_t;

   logic        clkcnt;
   logic        rst;
   logic        sigIn;
   logic        measReady;
   logic        measReady4;
   logic [15:0] meas16;
   logic        valid16, sat16, busy16;
   logic [3:0]  meas4;
   logic        valid4, sat4, busy4;
`ifdef PERIOD_METER_OVERRUN_EN
   logic        ovr16, ovr4;
`endif

   meas_t q16[$];
   meas_t q4[$];
   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    lastRise = 0;
   bit    armed = 0;
   bit    streamCheck = 1;
   logic  prevSig = 1'b0;

   period_meter #(.COUNT_WIDTH(16), .SYNC_STAGES(2)) dut16 (
      .rst        (rst),
      .clkcnt     (clkcnt),
      .sig_in     (sigIn),
      .meas_ready (measReady),
      .meas       (meas16),
      .meas_valid (valid16),
      .meas_sat   (sat16),
      .busy       (busy16)
`ifdef PERIOD_METER_OVERRUN_EN
      ,
      .overrun    (ovr16)
`endif
   );

   period_meter #(.COUNT_WIDTH(4), .SYNC_STAGES(2)) dut4 (
      .rst        (rst),
      .clkcnt     (clkcnt),
      .sig_in     (sigIn),
      .meas_ready (measReady4),
      .meas       (meas4),
      .meas_valid (valid4),
      .meas_sat   (sat4),
      .busy       (busy4)
`ifdef PERIOD_METER_OVERRUN_EN
      ,
      .overrun    (ovr4)
`endif
   );

   // Free-running measurement clock
   initial clkcnt = 1'b0;
   always #5 clkcnt = ~clkcnt;

   // Hard stop in case something wedges the stimulus sequence
   initial begin
      #400000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: each driven rise closes the period since the previous one;
   // the counter tops out at all-ones, which also sets the sat flag.
   task automatic noteRise(input int c);
      int    diff;
      meas_t m;
      if (armed) begin
         diff = c - lastRise;
         if (streamCheck) begin
            m.val = (diff >= 65535) ? 65535 : diff;
            m.sat = (diff >= 65535);
            q16.push_back(m);
         end
         m.val = (diff >= 15) ? 15 : diff;
         m.sat = (diff >= 15);
         q4.push_back(m);
      end
      lastRise = c;
      armed    = 1'b1;
   endtask

   task automatic checkOutput();
      meas_t m;
      if (streamCheck && valid16) begin
         if (q16.size() == 0) begin
            check("valid16_unexpected", 32'(valid16), 32'd0);
         end else begin
            m = q16.pop_front();
            check("meas16", 32'(meas16), m.val);
            check("sat16", 32'(sat16), 32'(m.sat));
         end
      end
      if (valid4) begin
         if (q4.size() == 0) begin
            check("valid4_unexpected", 32'(valid4), 32'd0);
         end else begin
            m = q4.pop_front();
            check("meas4", 32'(meas4), m.val);
            check("sat4", 32'(sat4), 32'(m.sat));
         end
      end
   endtask

   // One clkcnt cycle: sample outputs at the falling edge, then drive sig_in
   task automatic applyStimulus(input logic s);
      @(negedge clkcnt);
      cyc++;
      checkOutput();
      sigIn = s;
      if (s && !prevSig && !rst) noteRise(cyc);
      prevSig = s;
   endtask

   task automatic runPeriod(input int p, input int h);
      for (int i = 0; i < p; i++) applyStimulus(i < h);
   endtask

   task automatic drain();
      for (int i = 0; i < 6; i++) applyStimulus(1'b0);
      check("q16_drained", q16.size(), 32'd0);
      check("q4_drained", q4.size(), 32'd0);
   endtask

   initial begin
      int p;
      int h;
      rst        = 1'b1;
      sigIn      = 1'b0;
      measReady  = 1'b1;
      measReady4 = 1'b1;
      repeat (3) applyStimulus(1'b0);

      check("rst_meas16", 32'(meas16), 32'd0);
      check("rst_valid16", 32'(valid16), 32'd0);
      check("rst_sat16", 32'(sat16), 32'd0);
      check("rst_busy16", 32'(busy16), 32'd0);
      check("rst_valid4", 32'(valid4), 32'd0);
`ifdef PERIOD_METER_OVERRUN_EN
      check("rst_overrun16", 32'(ovr16), 32'd0);
`endif
      rst = 1'b0;
      repeat (2) applyStimulus(1'b0);
      check("idle_busy16", 32'(busy16), 32'd0);

      // Period-10 square wave: first rise arms, then 10 every period
      runPeriod(10, 5);
      check("armed_busy16", 32'(busy16), 32'd1);
      check("armed_busy4", 32'(busy4), 32'd1);
      repeat (3) runPeriod(10, 5);
      drain();

      // Fastest input: toggling every cycle
      repeat (6) runPeriod(2, 1);
      drain();

      // Period 20 saturates the 4-bit meter
      repeat (3) runPeriod(20, 10);
      drain();

      // Random periods and duty cycles
      for (int i = 0; i < 30; i++) begin
         p = int'($urandom_range(2, 24));
         h = int'($urandom_range(1, p - 1));
         runPeriod(p, h);
      end
      drain();

      // Consumer stall across two captures: 10 is held, 12 is dropped
      runPeriod(10, 5);
      measReady   = 1'b0;
      streamCheck = 1'b0;
      runPeriod(12, 6);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(i < 6);
         if (i == 8) begin
            check("stall_meas16", 32'(meas16), 32'd10);
            check("stall_valid16", 32'(valid16), 32'd1);
            check("stall_sat16", 32'(sat16), 32'd0);
`ifdef PERIOD_METER_OVERRUN_EN
            check("stall_overrun16", 32'(ovr16), 32'd1);
`endif
            measReady = 1'b1;
         end
         if (i == 9) begin
            check("read_valid16", 32'(valid16), 32'd0);
`ifdef PERIOD_METER_OVERRUN_EN
            check("read_overrun16", 32'(ovr16), 32'd0);
`endif
         end
      end
      streamCheck = 1'b1;
      runPeriod(12, 6);
      drain();

      // Read coinciding with a new capture: 8 held, then 9 replaces it
      runPeriod(8, 4);
      measReady   = 1'b0;
      streamCheck = 1'b0;
      runPeriod(9, 4);
      check("hold_meas16", 32'(meas16), 32'd8);
      check("hold_valid16", 32'(valid16), 32'd1);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(i < 4);
         if (i == 3) measReady = 1'b1;
         if (i == 4) begin
            check("swap_meas16", 32'(meas16), 32'd9);
            check("swap_valid16", 32'(valid16), 32'd1);
`ifdef PERIOD_METER_OVERRUN_EN
            check("swap_overrun16", 32'(ovr16), 32'd0);
`endif
         end
         if (i == 5) check("swap_read_valid16", 32'(valid16), 32'd0);
      end
      streamCheck = 1'b1;
      drain();

      // Reset in the middle of a measurement
      runPeriod(10, 5);
      repeat (3) applyStimulus(1'b0);
      check("pre_rst_busy16", 32'(busy16), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_meas16", 32'(meas16), 32'd0);
      check("mid_rst_valid16", 32'(valid16), 32'd0);
      check("mid_rst_sat16", 32'(sat16), 32'd0);
      check("mid_rst_busy16", 32'(busy16), 32'd0);
      check("mid_rst_meas4", 32'(meas4), 32'd0);
      check("mid_rst_busy4", 32'(busy4), 32'd0);
`ifdef PERIOD_METER_OVERRUN_EN
      check("mid_rst_overrun16", 32'(ovr16), 32'd0);
`endif
      q16.delete();
      q4.delete();
      armed = 1'b0;
      repeat (2) applyStimulus(1'b0);
      rst = 1'b0;
      repeat (2) applyStimulus(1'b0);
      check("post_rst_busy16", 32'(busy16), 32'd0);
      repeat (3) runPeriod(10, 5);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/period_meter.md
# period_meter

Measures the period of an asynchronous input signal in units of the divided clock `clkcnt`, as the inverse of the divided-clock counter: that block turns a clock into a count, this one turns an external signal's edges into a count. It synchronises `sig_in`, detects rising edges and counts `clkcnt` cycles between consecutive edges. Each completed measurement is presented on a valid/ready output with saturation flagging. It sits alongside the clock divider / counter blocks and feeds measurement consumers such as display or UART formatters.

## Interface
- `COUNT_WIDTH`, 16: width of the period counter and of the `meas` output.
- `SYNC_STAGES`, 2: number of flip-flops in the `sig_in` synchroniser; minimum 2.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `clkcnt` input, 1 bit: clock; all logic is on its rising edge.
- `sig_in` input, 1 bit: asynchronous signal being measured.
- `meas_ready` input, 1 bit: consumer accepts `meas`.
- `meas` output, `COUNT_WIDTH` bits: last measured period, in `clkcnt` cycles.
- `meas_valid` output, 1 bit: `meas` holds an unconsumed measurement.
- `meas_sat` output, 1 bit: the measurement in `meas` saturated.
- `busy` output, 1 bit: high in MEASURE state.
- `overrun` output, 1 bit: present only with `PERIOD_METER_OVERRUN_EN`; sticky flag for a dropped measurement.

## Operation
- **Reset values:** `meas=0`, `meas_valid=0`, `meas_sat=0`, `busy=0`, `overrun=0`. The synchroniser, edge register and counter are all 0, and the state is IDLE.
- **Edge detect:** the synchronised `sig_in` is compared with its one-cycle-delayed copy. A rise (0 to 1) gives a 1-cycle `edge` pulse.
- **IDLE:**
  - On `edge`, load counter = 1 and go to MEASURE.
  - No measurement is produced (the first edge only arms the block).
- **MEASURE:**
  - Each cycle without `edge`, the counter increments and saturates at 2^COUNT_WIDTH−1.
  - On `edge`, capture the counter value as the period, then reload counter = 1 and stay in MEASURE.
  - Edges detected at cycles t0 and t1 therefore yield a period of t1−t0.
- **Saturation:** if the counter equals all-ones when captured, `meas` = all-ones and `meas_sat` = 1. Otherwise `meas_sat` = 0.
- **Output handshake:**
  - A transfer occurs on a `clkcnt` edge when `meas_valid` and `meas_ready` are both 1.
  - `meas`, `meas_sat` and `meas_valid` stay stable until the transfer.
  - After a transfer with no new capture, `meas_valid` drops to 0.
- **Capture while empty, or on the same cycle as a transfer:** load the new `meas`/`meas_sat`; `meas_valid` = 1.
- **Capture while `meas_valid`=1 and `meas_ready`=0:** the new measurement is dropped and the old one is retained. The counter still reloads.
- **Reset mid-operation:** everything returns to the reset values. The first edge after reset only arms the block.

## Timing
- A `sig_in` rise stable before a `clkcnt` edge produces `edge` SYNC_STAGES+1 cycles later.
- `meas_valid` rises 1 cycle after the capturing `edge` (registered output).
- Minimum measurable period is 2, since the synchronised signal needs at least 1 cycle high and 1 cycle low.
- Per-edge synchroniser uncertainty is ±1 cycle.
- `busy` rises 1 cycle after the arming edge.

## Configuration
- **`PERIOD_METER_OVERRUN_EN` defined:**
  - `overrun` port exists.
  - It is set to 1 on the cycle after a dropped capture.
  - It stays set until reset, or until a transfer that happens while no new capture is dropped (clear on successful read).
- **Undefined:** the `overrun` port and its logic are absent; drop behaviour is unchanged.

## Structure
- Package `period_meter_pkg`:
  - state enum `pm_state_t` {IDLE, MEASURE};
  - localparam `PM_SYNC_MIN = 2`.
- Sub-module `sync_edge_detect`: holds the SYNC_STAGES synchroniser plus the rising-edge detector, with parameter `SYNC_STAGES`, ports `clk`, `rst`, `d`, `rise`.
- The top level holds the FSM, the saturating counter and the output holding register.

## Test plan
- `sig_in` square wave with period 10 `clkcnt`, `meas_ready`=1: no output after the first edge, then `meas`=10, `meas_sat`=0, `meas_valid` pulsing once per period.
- `sig_in` toggling every 1 `clkcnt` cycle (period 2): `meas`=2 for every edge.
- `COUNT_WIDTH`=4, period 20: `meas`=15, `meas_sat`=1.
- `meas_ready`=0 across two captures (period 10, then period 12):
  - `meas` stays 10 and `meas_valid` stays 1;
  - with the macro, `overrun`=1;
  - raise `meas_ready`: transfer occurs, then `overrun`=0 (macro) and the next value is 12.
- `meas_ready` asserted on the same cycle as a new capture (periods 8 then 9): 9 is loaded and `meas_valid` stays 1.
- Assert `rst` mid-measurement: all outputs 0 and `busy`=0. With period 10, the next edge only arms, and the first `meas`=10 arrives one period later.
